// File: rtl/mdu_seq.sv
// Multi-cycle unsigned multiply/divide sequencer. Owns HI/LO and drives a
// shared external 32-bit ALU one step per cycle (shift-and-add multiply,
// restoring divide).
module mdu_seq #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] alu_ans,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [31:0]   acc, q, opnd;
  logic [CW-1:0] cnt;
  logic [31:0]   step_acc, step_q;
  logic [32:0]   s;
  logic          carry, borrow, last;

  assign last = (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start && md_op == OP_MULTU) state_next = MUL;
        else if (start && md_op == OP_DIVU) state_next = DIV;
      end
      MUL, DIV: if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU drive and one multiply/divide step computed from the working registers.
  always_comb begin
    alu_in1  = '0;
    alu_in2  = '0;
    alu_op   = ALU_ADD;
    step_acc = acc;
    step_q   = q;
    s        = {acc, q[31]};
    carry    = 1'b0;
    borrow   = 1'b0;
    unique case (state)
      MUL: begin
        alu_in1 = acc;
        alu_in2 = opnd;
        alu_op  = ALU_ADD;
        carry   = (alu_ans < acc);
        if (q[0]) {step_acc, step_q} = {carry, alu_ans, q[31:1]};
        else      {step_acc, step_q} = {1'b0, acc, q[31:1]};
      end
      DIV: begin
        alu_in1 = s[31:0];
        alu_in2 = opnd;
        alu_op  = ALU_SUB;
        borrow  = (s[31:0] < opnd);
        // s[32] set means the 33-bit partial remainder exceeds any divisor,
        // so the truncated ALU difference is still the exact remainder.
        if (s[32] || !borrow) begin
          step_acc = alu_ans;
          step_q   = {q[30:0], 1'b1};
        end else begin
          step_acc = s[31:0];
          step_q   = {q[30:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Working registers, HI/LO, busy and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      q    <= '0;
      opnd <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (md_op)
              OP_MULTU: begin
                acc  <= '0;
                q    <= rt;
                opnd <= rs;
                cnt  <= '0;
                busy <= 1'b1;
              end
              OP_DIVU: begin
                acc  <= '0;
                q    <= rs;
                opnd <= rt;
                cnt  <= '0;
                busy <= 1'b1;
              end
              OP_MTHI: hi <= rs;
              OP_MTLO: lo <= rs;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (last) begin
            hi   <= step_acc;
            lo   <= step_q;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            acc <= step_acc;
            q   <= step_q;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural model of the shared ALU.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  md_op;
  logic [31:0] rs, rt, alu_ans, alu_in1, alu_in2, hi, lo;
  logic [1:0]  alu_op;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  mdu_seq #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .rs(rs), .rt(rt),
    .alu_ans(alu_ans), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Shared ALU: add / sub / or.
  always_comb begin
    case (alu_op)
      2'b00:   alu_ans = alu_in1 + alu_in2;
      2'b01:   alu_ans = alu_in1 - alu_in2;
      2'b10:   alu_ans = alu_in1 | alu_in2;
      default: alu_ans = '0;
    endcase
  end

  // Present a command for one cycle, returning at the first negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles and ALU-op deviations; returns at the first negedge with busy low.
  task automatic wait_op(input logic [1:0] exp_op, output int cyc, output int bad_op);
    cyc = 0; bad_op = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (alu_op !== exp_op) bad_op++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; md_op = 2'b00; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
    checks++; if ({alu_in1, alu_in2, alu_op} !== 66'h0) begin errors++;
      $display("FAIL reset_alu_idle got in1=%h in2=%h op=%0d exp=0", alu_in1, alu_in2, alu_op); end
  endtask

  task automatic test_mul_small;
    int cyc, bad;
    issue(2'b00, 32'd7, 32'd6);
    wait_op(2'b00, cyc, bad);
    checks++; if (cyc != 32) begin errors++; $display("FAIL mul_small_busy got=%0d exp=32", cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mul_small_done got=%0b exp=1", done); end
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL mul_small got=%h_%h exp=0_2a", hi, lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_small_done_width got=%0b exp=0", done); end
  endtask

  task automatic test_mul_carry;
    int cyc, bad;
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_op(2'b00, cyc, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL mul_aluop got=%0d bad cycles exp=0", bad); end
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h1) begin errors++;
      $display("FAIL mul_carry got=%h_%h exp=fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_div;
    int cyc, bad;
    issue(2'b01, 32'd100, 32'd7);
    wait_op(2'b01, cyc, bad);
    checks++; if (cyc != 32 || bad != 0) begin errors++; $display("FAIL div_100_7_timing got cyc=%0d bad=%0d exp 32/0", cyc, bad); end
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL div_100_7 got=%h_%h exp=2_e", hi, lo); end
    issue(2'b01, 32'h80000000, 32'd3);
    wait_op(2'b01, cyc, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL div_msb_aluop got=%0d bad cycles exp=0", bad); end
    checks++; if (hi !== 32'd2 || lo !== 32'h2AAAAAAA) begin errors++; $display("FAIL div_msb got=%h_%h exp=2_2aaaaaaa", hi, lo); end
  endtask

  task automatic test_div_zero_and_moves;
    int cyc, bad;
    issue(2'b01, 32'h12345678, 32'd0);
    repeat (3) @(negedge clk);
    start = 1'b1; md_op = 2'b10; rs = 32'hA5A5A5A5;
    @(negedge clk);
    start = 1'b0;
    wait_op(2'b01, cyc, bad);
    checks++; if (cyc != 28) begin errors++; $display("FAIL div0_busy_remaining got=%0d exp=28", cyc); end
    checks++; if (hi !== 32'h12345678 || lo !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL div0 got=%h_%h exp=12345678_ffffffff", hi, lo); end
    @(negedge clk);
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_while_busy got=%h exp=12345678", hi); end
    issue(2'b10, 32'hCAFEF00D, 32'd0);
    checks++; if (hi !== 32'hCAFEF00D || busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL mthi_idle got hi=%h busy=%0b done=%0b exp=cafef00d/0/0", hi, busy, done); end
    issue(2'b11, 32'h0BADBEEF, 32'd0);
    checks++; if (lo !== 32'h0BADBEEF || hi !== 32'hCAFEF00D || busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL mtlo_idle got hi=%h lo=%h busy=%0b done=%0b exp=cafef00d/0badbeef/0/0", hi, lo, busy, done); end
  endtask

  task automatic test_reset_abort;
    int cyc, bad, dcount;
    issue(2'b00, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL abort_flags got busy=%0b done=%0b exp=0/0", busy, done); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_hilo got=%h_%h exp=0_0", hi, lo); end
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1 || busy === 1'b1) dcount++;
      @(negedge clk);
    end
    checks++; if (dcount != 0) begin errors++; $display("FAIL abort_quiet got=%0d active cycles exp=0", dcount); end
    issue(2'b00, 32'd3, 32'd5);
    wait_op(2'b00, cyc, bad);
    checks++; if (hi !== 32'd0 || lo !== 32'd15) begin errors++; $display("FAIL after_abort_mul got=%h_%h exp=0_f", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int cyc, bad;
    issue(2'b00, 32'd2, 32'd3);
    wait_op(2'b00, cyc, bad);
    checks++; if (lo !== 32'd6 || done !== 1'b1) begin errors++; $display("FAIL b2b_first got lo=%h done=%0b exp=6/1", lo, done); end
    start = 1'b1; md_op = 2'b01; rs = 32'd9; rt = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_op(2'b01, cyc, bad);
    checks++; if (cyc != 32) begin errors++; $display("FAIL b2b_busy got=%0d exp=32", cyc); end
    checks++; if (hi !== 32'd1 || lo !== 32'd4) begin errors++; $display("FAIL b2b_div got=%h_%h exp=1_4", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mul_small();
    test_mul_carry();
    test_div();
    test_div_zero_and_moves();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
